in_service_control: RTL

IN_SERVICE_CONTROL -- requirements
Module: in_service_control

---
 rtl/in_service_control_if.sv | 32 +++
 rtl/in_service_control.sv | 128 ++++++++++++
 2 files changed

// File: rtl/in_service_control_if.sv
// Bus between the 8259-style in-service block, the priority resolver, the command
// registers and the CPU acknowledge path.
interface in_service_control_if;
    logic [7:0] interrupt_from_priority_resolver;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       rotate_on_eoi;
    logic       int_out;
    logic [7:0] clear_request;
    logic [7:0] in_service_register;
    logic [2:0] rotate;
    logic [7:0] data_out;
    logic       data_out_enable;

    modport master (
        output interrupt_from_priority_resolver, inta_n, vector_base, auto_eoi,
               eoi_valid, eoi_specific, eoi_level, rotate_on_eoi,
        input  int_out, clear_request, in_service_register, rotate, data_out,
               data_out_enable
    );

    modport slave (
        input  interrupt_from_priority_resolver, inta_n, vector_base, auto_eoi,
               eoi_valid, eoi_specific, eoi_level, rotate_on_eoi,
        output int_out, clear_request, in_service_register, rotate, data_out,
               data_out_enable
    );
endinterface

// File: rtl/in_service_control.sv
// In-service register and INTA sequencer: tracks acknowledged levels, drives the
// vector byte on the second INTA pulse and handles EOI / AEOI with optional rotation.
module in_service_control (
    input logic                  clock,
    input logic                  reset,
    in_service_control_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StAck1, StWait2, StAck2} state_e;

    state_e     state_q, state_d;
    logic       prev_inta_n_q;
    logic [2:0] level_q, level_d;
    logic       spurious_q, spurious_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] rotate_q, rotate_d;
    logic       int_out_q, int_out_d;
    logic [7:0] clear_request_q, clear_request_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_out_enable_q, data_out_enable_d;

    logic       inta_fall, inta_rise, ack_take, aeoi_clear;
    logic [7:0] irq;
    logic [2:0] irq_level;
    logic       ns_found;
    logic [2:0] ns_level, scan_idx;
    logic [7:0] set_mask, clear_mask;

    assign irq       = bus.interrupt_from_priority_resolver;
    assign inta_fall = prev_inta_n_q & ~bus.inta_n;
    assign inta_rise = ~prev_inta_n_q & bus.inta_n;
    assign ack_take  = (state_q == StIdle) && inta_fall;
    assign aeoi_clear = (state_q == StAck2) && inta_rise && bus.auto_eoi && !spurious_q;

    // Spurious acknowledge (no request) reports the lowest level, IR7.
    always_comb begin
        irq_level = 3'd7;
        for (int i = 0; i < 8; i++) begin
            if (irq[i]) irq_level = 3'(i);
        end
    end

    // Non-specific EOI: first set bit scanning upward from the level after rotate.
    always_comb begin
        ns_found = 1'b0;
        ns_level = 3'd0;
        scan_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = rotate_q + 3'd1 + 3'(i);
            if (!ns_found && isr_q[scan_idx]) begin
                ns_found = 1'b1;
                ns_level = scan_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= StIdle;
            prev_inta_n_q     <= 1'b1;
            level_q           <= 3'd7;
            spurious_q        <= 1'b0;
            isr_q             <= 8'h00;
            rotate_q          <= 3'b111;
            int_out_q         <= 1'b0;
            clear_request_q   <= 8'h00;
            data_out_q        <= 8'h00;
            data_out_enable_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            prev_inta_n_q     <= bus.inta_n;
            level_q           <= level_d;
            spurious_q        <= spurious_d;
            isr_q             <= isr_d;
            rotate_q          <= rotate_d;
            int_out_q         <= int_out_d;
            clear_request_q   <= clear_request_d;
            data_out_q        <= data_out_d;
            data_out_enable_q <= data_out_enable_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (inta_fall) state_d = StAck1;
            StAck1:  if (inta_rise) state_d = StWait2;
            StWait2: if (inta_fall) state_d = StAck2;
            StAck2:  if (inta_rise) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        int_out_d       = (state_q == StIdle) && !inta_fall && (irq != 8'h00);
        clear_request_d = ack_take ? irq : 8'h00;
        set_mask        = ack_take ? irq : 8'h00;
        level_d         = ack_take ? irq_level : level_q;
        spurious_d      = ack_take ? (irq == 8'h00) : spurious_q;

        clear_mask = 8'h00;
        rotate_d   = rotate_q;
        if (aeoi_clear) begin
            clear_mask = clear_mask | (8'h01 << level_q);
            if (bus.rotate_on_eoi) rotate_d = level_q;
        end
        // EOI rotation is applied last so it overrides an AEOI rotation.
        if (bus.eoi_valid) begin
            if (bus.eoi_specific) begin
                clear_mask = clear_mask | (8'h01 << bus.eoi_level);
                if (bus.rotate_on_eoi) rotate_d = bus.eoi_level;
            end else if (ns_found) begin
                clear_mask = clear_mask | (8'h01 << ns_level);
                if (bus.rotate_on_eoi) rotate_d = ns_level;
            end
        end
        isr_d = (isr_q & ~clear_mask) | set_mask;

        data_out_enable_d = (state_d == StAck2);
        data_out_d        = data_out_enable_d ? {bus.vector_base, level_q} : 8'h00;
    end

    assign bus.int_out             = int_out_q;
    assign bus.clear_request       = clear_request_q;
    assign bus.in_service_register = isr_q;
    assign bus.rotate              = rotate_q;
    assign bus.data_out            = data_out_q;
    assign bus.data_out_enable     = data_out_enable_q;
endmodule
